reg_writeback: RTL and testbench

//  Writeback stage directly upstream of the register file in the multi-cycle X-Makina core.

---
 rtl/reg_writeback_if.sv | 57 +++++
 rtl/reg_writeback.sv | 157 +++++++++++++++
 tb/tb_reg_writeback.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_writeback_if.sv
// Writeback stage port bundle: ALU/load inputs, register file write and PC ports.
// Master drives results toward the stage; slave is the writeback stage itself.
interface reg_writeback_if #(
  parameter int WORD      = 16,
  parameter int REGISTERS = 8
);
  localparam int AW = $clog2(REGISTERS);
  localparam int NB = WORD / 8;

  logic            alu_valid_i;
  logic            alu_ready_o;
  logic [AW-1:0]   alu_dst_i;
  logic            alu_byte_i;
  logic [WORD-1:0] alu_data_i;

  logic            ld_req_i;
  logic [AW-1:0]   ld_dst_i;
  logic            ld_byte_i;
  logic            mem_valid_i;
  logic [WORD-1:0] mem_data_i;
  logic            ld_busy_o;
  logic            ld_err_o;

  logic            pc_inc_i;
  logic            pc_ld_i;
  logic [WORD-1:0] pc_target_i;
  logic [WORD-1:0] rf_pc_i;

  logic            wrEn_o;
  logic [NB-1:0]   wrMode_o;
  logic [AW-1:0]   wrAddr_o;
  logic [WORD-1:0] wrData_o;
  logic            pcEn_o;
  logic [WORD-1:0] pc_o;

  modport master (
    output alu_valid_i, alu_dst_i, alu_byte_i,
    output alu_data_i, ld_req_i, ld_dst_i,
    output ld_byte_i, mem_valid_i, mem_data_i,
    output pc_inc_i, pc_ld_i, pc_target_i,
    output rf_pc_i,
    input  alu_ready_o, ld_busy_o, ld_err_o,
    input  wrEn_o, wrMode_o, wrAddr_o,
    input  wrData_o, pcEn_o, pc_o
  );

  modport slave (
    input  alu_valid_i, alu_dst_i, alu_byte_i,
    input  alu_data_i, ld_req_i, ld_dst_i,
    input  ld_byte_i, mem_valid_i, mem_data_i,
    input  pc_inc_i, pc_ld_i, pc_target_i,
    input  rf_pc_i,
    output alu_ready_o, ld_busy_o, ld_err_o,
    output wrEn_o, wrMode_o, wrAddr_o,
    output wrData_o, pcEn_o, pc_o
  );
endinterface

// File: rtl/reg_writeback.sv
// Writeback stage feeding the register file write and PC ports.
// Optional load timeout: define WB_LD_TIMEOUT_EN.
module reg_writeback #(
  parameter int WORD       = 16,
  parameter int REGISTERS  = 8,
  parameter int PC         = 7,
  parameter int LD_TIMEOUT = 15
) (
  input logic            clk_i,
  input logic            rst_ni,
  reg_writeback_if.slave wb
);
  localparam int AW = $clog2(REGISTERS);
  localparam int NB = WORD / 8;

  if ((WORD % 8) != 0 || LD_TIMEOUT < 1) begin : g_bad_cfg
    $error("reg_writeback: bad parameters");
  end

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    WB
  } state_t;

  typedef struct packed {
    logic            en;
    logic [NB-1:0]   mode;
    logic [AW-1:0]   addr;
    logic [WORD-1:0] data;
  } wr_t;

  state_t          state;
  logic [AW-1:0]   ld_dst;
  logic            ld_byte;
  wr_t             wr;
  wr_t             wr_nxt;
  logic            pc_en;
  logic [WORD-1:0] pc_q;
  logic [WORD-1:0] pc_nxt;
  logic            pc_req;
  logic            pc_hit;
  logic            ld_land;
  logic            alu_ready;
  logic            alu_fire;
  logic            ld_tmo;
  logic            ld_err;

  // A landing load owns the write slot, so the ALU is held off that cycle too
  assign ld_land   = (state == WAIT) && wb.mem_valid_i;
  assign alu_ready = rst_ni && (state != WB) && !ld_land;
  assign alu_fire  = wb.alu_valid_i && alu_ready;

`ifdef WB_LD_TIMEOUT_EN
  localparam int CW = $clog2(LD_TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt;

  assign ld_tmo = (state == WAIT) && !wb.mem_valid_i
               && (tmo_cnt == CW'(LD_TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tmo_cnt <= '0;
      ld_err  <= 1'b0;
    end else begin
      ld_err <= ld_tmo;
      if (state != WAIT || wb.mem_valid_i || ld_tmo)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign ld_tmo = 1'b0;
  assign ld_err = 1'b0;
`endif

  always_comb begin
    wr_nxt    = wr;
    wr_nxt.en = 1'b0;
    unique case (1'b1)
      ld_land: begin
        wr_nxt.en   = 1'b1;
        wr_nxt.addr = ld_dst;
        wr_nxt.mode = '1;
        wr_nxt.data = ld_byte
                    ? WORD'(wb.mem_data_i[7:0])
                    : wb.mem_data_i;
      end
      alu_fire: begin
        wr_nxt.en   = 1'b1;
        wr_nxt.addr = wb.alu_dst_i;
        wr_nxt.mode = wb.alu_byte_i ? NB'(1) : '1;
        wr_nxt.data = wb.alu_data_i;
      end
      default: ;
    endcase
  end

  assign pc_req = wb.pc_inc_i || wb.pc_ld_i;
  assign pc_nxt = wb.pc_ld_i
                ? wb.pc_target_i
                : wb.rf_pc_i + WORD'(2);
  // A general write to the PC register wins over the PC port
  assign pc_hit = wr_nxt.en && (wr_nxt.addr == AW'(PC));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state   <= IDLE;
      ld_dst  <= '0;
      ld_byte <= 1'b0;
      wr      <= '0;
      pc_en   <= 1'b0;
      pc_q    <= '0;
    end else begin
      wr    <= wr_nxt;
      pc_en <= pc_req && !pc_hit;
      if (pc_req)
        pc_q <= pc_nxt;
      unique case (state)
        IDLE: begin
          if (wb.ld_req_i) begin
            state   <= WAIT;
            ld_dst  <= wb.ld_dst_i;
            ld_byte <= wb.ld_byte_i;
          end
        end
        WAIT: begin
          if (wb.mem_valid_i)
            state <= WB;
          else if (ld_tmo)
            state <= IDLE;
        end
        WB: begin
          if (wb.ld_req_i) begin
            state   <= WAIT;
            ld_dst  <= wb.ld_dst_i;
            ld_byte <= wb.ld_byte_i;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wb.alu_ready_o = alu_ready;
  assign wb.ld_busy_o   = (state == WAIT);
  assign wb.ld_err_o    = ld_err;
  assign wb.wrEn_o      = wr.en;
  assign wb.wrMode_o    = wr.mode;
  assign wb.wrAddr_o    = wr.addr;
  assign wb.wrData_o    = wr.data;
  assign wb.pcEn_o      = pc_en;
  assign wb.pc_o        = pc_q;
endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: ALU/load writes, arbitration, PC, reset.
// Timeout steps run only when WB_LD_TIMEOUT_EN is defined.
module tb_reg_writeback;
  localparam int WORD       = 16;
  localparam int REGISTERS  = 8;
  localparam int LD_TIMEOUT = 15;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  reg_writeback_if #(
    .WORD(WORD),
    .REGISTERS(REGISTERS)
  ) wb ();

  reg_writeback #(
    .WORD(WORD),
    .REGISTERS(REGISTERS),
    .PC(7),
    .LD_TIMEOUT(LD_TIMEOUT)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .wb(wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    wb.alu_valid_i = 1'b0;
    wb.alu_dst_i   = '0;
    wb.alu_byte_i  = 1'b0;
    wb.alu_data_i  = '0;
    wb.ld_req_i    = 1'b0;
    wb.ld_dst_i    = '0;
    wb.ld_byte_i   = 1'b0;
    wb.mem_valid_i = 1'b0;
    wb.mem_data_i  = '0;
    wb.pc_inc_i    = 1'b0;
    wb.pc_ld_i     = 1'b0;
    wb.pc_target_i = '0;
    wb.rf_pc_i     = '0;

    // reset
    step();
    step();
    chk("rst_wren", wb.wrEn_o, 0);
    chk("rst_pcen", wb.pcEn_o, 0);
    chk("rst_pc", wb.pc_o, 0);
    chk("rst_busy", wb.ld_busy_o, 0);
    chk("rst_err", wb.ld_err_o, 0);
    chk("rst_mode", wb.wrMode_o, 0);
    chk("rst_rdy", wb.alu_ready_o, 0);
    rst_n = 1'b1;
    step();
    chk("idle_rdy", wb.alu_ready_o, 1);

    // ALU word write
    wb.alu_valid_i = 1'b1;
    wb.alu_dst_i   = 3'd3;
    wb.alu_data_i  = 16'hBEEF;
    wb.alu_byte_i  = 1'b0;
    step();
    wb.alu_valid_i = 1'b0;
    chk("aw_en", wb.wrEn_o, 1);
    chk("aw_addr", wb.wrAddr_o, 3);
    chk("aw_mode", wb.wrMode_o, 2'b11);
    chk("aw_data", wb.wrData_o, 16'hBEEF);
    chk("aw_rdy", wb.alu_ready_o, 1);
    step();
    chk("aw_pulse", wb.wrEn_o, 0);

    // ALU byte write
    wb.alu_valid_i = 1'b1;
    wb.alu_dst_i   = 3'd4;
    wb.alu_data_i  = 16'h1234;
    wb.alu_byte_i  = 1'b1;
    step();
    wb.alu_valid_i = 1'b0;
    wb.alu_byte_i  = 1'b0;
    chk("ab_en", wb.wrEn_o, 1);
    chk("ab_addr", wb.wrAddr_o, 4);
    chk("ab_mode", wb.wrMode_o, 2'b01);
    chk("ab_lo", wb.wrData_o[7:0], 8'h34);

    // byte load, data 4 cycles after request
    wb.ld_req_i  = 1'b1;
    wb.ld_dst_i  = 3'd2;
    wb.ld_byte_i = 1'b1;
    step();
    wb.ld_req_i  = 1'b0;
    wb.ld_byte_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bl_busy", wb.ld_busy_o, 1);
      chk("bl_nowr", wb.wrEn_o, 0);
      step();
    end
    wb.mem_valid_i = 1'b1;
    wb.mem_data_i  = 16'h12A5;
    #1;
    chk("bl_busy4", wb.ld_busy_o, 1);
    chk("bl_land_rdy", wb.alu_ready_o, 0);
    step();
    wb.mem_valid_i = 1'b0;
    chk("bl_en", wb.wrEn_o, 1);
    chk("bl_addr", wb.wrAddr_o, 2);
    chk("bl_data", wb.wrData_o, 16'h00A5);
    chk("bl_mode", wb.wrMode_o, 2'b11);
    chk("bl_wb_busy", wb.ld_busy_o, 0);
    chk("bl_wb_rdy", wb.alu_ready_o, 0);
    step();
    chk("bl_done", wb.wrEn_o, 0);
    chk("bl_idle_rdy", wb.alu_ready_o, 1);

    // conflict: load lands while ALU is offering
    wb.ld_req_i = 1'b1;
    wb.ld_dst_i = 3'd6;
    step();
    wb.ld_req_i = 1'b0;
    step();
    wb.mem_valid_i = 1'b1;
    wb.mem_data_i  = 16'hCAFE;
    wb.alu_valid_i = 1'b1;
    wb.alu_dst_i   = 3'd5;
    wb.alu_data_i  = 16'h5555;
    #1;
    chk("cf_land_rdy", wb.alu_ready_o, 0);
    step();
    wb.mem_valid_i = 1'b0;
    chk("cf_ld_en", wb.wrEn_o, 1);
    chk("cf_ld_addr", wb.wrAddr_o, 6);
    chk("cf_ld_data", wb.wrData_o, 16'hCAFE);
    chk("cf_wb_rdy", wb.alu_ready_o, 0);
    // back-to-back load issued from WB
    wb.ld_req_i = 1'b1;
    wb.ld_dst_i = 3'd1;
    step();
    wb.ld_req_i = 1'b0;
    chk("cf_gap", wb.wrEn_o, 0);
    chk("cf_busy", wb.ld_busy_o, 1);
    chk("cf_rdy", wb.alu_ready_o, 1);
    step();
    wb.alu_valid_i = 1'b0;
    chk("cf_alu_en", wb.wrEn_o, 1);
    chk("cf_alu_addr", wb.wrAddr_o, 5);
    chk("cf_alu_data", wb.wrData_o, 16'h5555);
    wb.mem_valid_i = 1'b1;
    wb.mem_data_i  = 16'h0777;
    step();
    wb.mem_valid_i = 1'b0;
    chk("cf_ld2_addr", wb.wrAddr_o, 1);
    chk("cf_ld2_data", wb.wrData_o, 16'h0777);
    step();
    chk("cf_idle", wb.ld_busy_o, 0);

    // PC increment wraps
    wb.rf_pc_i  = 16'hFFFE;
    wb.pc_inc_i = 1'b1;
    step();
    wb.pc_inc_i = 1'b0;
    chk("pc_wrap_en", wb.pcEn_o, 1);
    chk("pc_wrap", wb.pc_o, 16'h0000);
    step();
    chk("pc_pulse", wb.pcEn_o, 0);
    wb.rf_pc_i  = 16'h0100;
    wb.pc_inc_i = 1'b1;
    step();
    chk("pc_inc", wb.pc_o, 16'h0102);
    // load beats increment
    wb.pc_ld_i     = 1'b1;
    wb.pc_target_i = 16'h0400;
    step();
    wb.pc_ld_i  = 1'b0;
    wb.pc_inc_i = 1'b0;
    chk("pc_ld_en", wb.pcEn_o, 1);
    chk("pc_ld", wb.pc_o, 16'h0400);
    // general write to r7 suppresses PC port
    wb.rf_pc_i     = 16'h0010;
    wb.pc_inc_i    = 1'b1;
    wb.alu_valid_i = 1'b1;
    wb.alu_dst_i   = 3'd7;
    wb.alu_data_i  = 16'h0AAA;
    step();
    chk("pc_hit_pcen", wb.pcEn_o, 0);
    chk("pc_hit_addr", wb.wrAddr_o, 7);
    chk("pc_hit_data", wb.wrData_o, 16'h0AAA);
    // write elsewhere leaves PC port alone
    wb.alu_dst_i = 3'd3;
    step();
    wb.pc_inc_i    = 1'b0;
    wb.alu_valid_i = 1'b0;
    chk("pc_miss_pcen", wb.pcEn_o, 1);
    chk("pc_miss_pc", wb.pc_o, 16'h0012);
    chk("pc_miss_wren", wb.wrEn_o, 1);

    // reset mid-load
    wb.ld_req_i = 1'b1;
    wb.ld_dst_i = 3'd2;
    step();
    wb.ld_req_i = 1'b0;
    step();
    chk("rl_busy", wb.ld_busy_o, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rl_busy0", wb.ld_busy_o, 0);
    chk("rl_wren0", wb.wrEn_o, 0);
    wb.mem_valid_i = 1'b1;
    wb.mem_data_i  = 16'h9999;
    step();
    wb.mem_valid_i = 1'b0;
    chk("rl_ign", wb.wrEn_o, 0);
    step();
    chk("rl_ign2", wb.wrEn_o, 0);
    chk("rl_idle", wb.ld_busy_o, 0);

`ifdef WB_LD_TIMEOUT_EN
    wb.ld_req_i = 1'b1;
    wb.ld_dst_i = 3'd4;
    step();
    wb.ld_req_i = 1'b0;
    for (int i = 0; i < LD_TIMEOUT - 1; i++) begin
      chk("to_busy", wb.ld_busy_o, 1);
      chk("to_noerr", wb.ld_err_o, 0);
      step();
    end
    step();
    chk("to_err", wb.ld_err_o, 1);
    chk("to_busy0", wb.ld_busy_o, 0);
    chk("to_nowr", wb.wrEn_o, 0);
    step();
    chk("to_pulse", wb.ld_err_o, 0);
`else
    chk("no_err", wb.ld_err_o, 0);
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
